// File: rtl/cv32e40p_rf_recovery_ctrl_pkg.sv
// Shared types and constants for the register-file checkpoint/restore controller.
// Optional parity protection of the shadow copy: CV32E40P_RF_RECOVERY_PARITY_EN.
package cv32e40p_rf_recovery_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BACKUP  = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } rf_rec_state_e;

    localparam int unsigned RF_REC_ADDR_W   = 6;
    localparam int unsigned RF_REC_DATA_W   = 32;
    localparam int unsigned RF_REC_BEAT_W   = 5;
    localparam int unsigned RF_REC_RD_LANES = 3;
    localparam int unsigned RF_REC_WR_LANES = 2;

    function automatic int unsigned rf_rec_ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/cv32e40p_rf_shadow.sv
// Shadow copy of the register file: three capture lanes, two combinational read lanes.
// With CV32E40P_RF_RECOVERY_PARITY_EN an even-parity bit is kept beside every word.
module cv32e40p_rf_shadow
    import cv32e40p_rf_recovery_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                                            clk,
    input  logic [RF_REC_RD_LANES-1:0]                      we,
    input  logic [RF_REC_RD_LANES-1:0][IDX_W-1:0]           waddr,
    input  logic [RF_REC_RD_LANES-1:0][RF_REC_DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]                                raddr_a,
    input  logic [IDX_W-1:0]                                raddr_b,
    output logic [RF_REC_DATA_W-1:0]                        rdata_a,
    output logic [RF_REC_DATA_W-1:0]                        rdata_b
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    ,
    output logic                                            rpar_a,
    output logic                                            rpar_b
`endif
);

    // Data is deliberately not reset; validity is tracked by the controller.
    logic [RF_REC_DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < RF_REC_RD_LANES; l++) begin
            if (we[l]) begin
                mem[waddr[l]] <= wdata[l];
            end
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic par [NUM_REGS];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < RF_REC_RD_LANES; l++) begin
            if (we[l]) begin
                par[waddr[l]] <= ^wdata[l];
            end
        end
    end

    assign rpar_a = par[raddr_a];
    assign rpar_b = par[raddr_b];
`endif

endmodule

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Sequences RF checkpoint (3 backup read lanes) and restore (2 recovery write ports).
// Parity checking of the shadow copy is enabled by CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl
    import cv32e40p_rf_recovery_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     backup_req_i,
    input  logic                     recover_req_i,
    output logic                     busy_o,
    output logic                     backup_done_o,
    output logic                     recover_done_o,
    output logic                     recover_err_o,
    output logic                     ckpt_valid_o,
    output logic                     regfile_backup_o,
    output logic [RF_REC_ADDR_W-1:0] regfile_raddr_ra_o,
    output logic [RF_REC_ADDR_W-1:0] regfile_raddr_rb_o,
    output logic [RF_REC_ADDR_W-1:0] regfile_raddr_rc_o,
    input  logic [RF_REC_DATA_W-1:0] regfile_rdata_ra_i,
    input  logic [RF_REC_DATA_W-1:0] regfile_rdata_rb_i,
    input  logic [RF_REC_DATA_W-1:0] regfile_rdata_rc_i,
    output logic                     recover_o,
    output logic [RF_REC_ADDR_W-1:0] regfile_waddr_a_o,
    output logic [RF_REC_ADDR_W-1:0] regfile_waddr_b_o,
    output logic [RF_REC_DATA_W-1:0] regfile_wdata_a_o,
    output logic [RF_REC_DATA_W-1:0] regfile_wdata_b_o,
    output logic                     regfile_we_a_o,
    output logic                     regfile_we_b_o
);

    localparam int unsigned BK_BEATS = rf_rec_ceil_div(NUM_REGS, RF_REC_RD_LANES);
    localparam int unsigned RS_BEATS = rf_rec_ceil_div(NUM_REGS - 1, RF_REC_WR_LANES);
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    rf_rec_state_e                                  state_q;
    logic [RF_REC_BEAT_W-1:0]                       beat_q;
    logic [RF_REC_BEAT_W-1:0]                       beat_nxt;
    logic                                           bk_last;
    logic                                           rs_last;
    int unsigned                                    bk_base;
    int unsigned                                    rs_base;
    logic [RF_REC_RD_LANES-1:0]                     cap_we;
    logic [RF_REC_RD_LANES-1:0][IDX_W-1:0]          cap_addr;
    logic [RF_REC_RD_LANES-1:0][RF_REC_DATA_W-1:0]  cap_data;
    logic [RF_REC_DATA_W-1:0]                       sh_rdata_a;
    logic [RF_REC_DATA_W-1:0]                       sh_rdata_b;
    logic                                           par_fail;

    // Addresses past the end of the register file collapse to 0.
    function automatic logic [RF_REC_ADDR_W-1:0] lane_addr(input int unsigned idx);
        return (idx < NUM_REGS) ? RF_REC_ADDR_W'(idx) : '0;
    endfunction

    always_comb begin
        bk_last  = (32'(beat_q) == BK_BEATS - 1);
        rs_last  = (32'(beat_q) == RS_BEATS - 1);
        beat_nxt = beat_q + RF_REC_BEAT_W'(1);
        bk_base  = 32'(beat_nxt) * RF_REC_RD_LANES;
        rs_base  = 32'(beat_nxt) * RF_REC_WR_LANES + 1;
        cap_we   = '0;
        for (int unsigned l = 0; l < RF_REC_RD_LANES; l++) begin
            cap_we[l] = (state_q == BACKUP) &&
                        ((32'(beat_q) * RF_REC_RD_LANES + l) < NUM_REGS);
        end
    end

    assign cap_addr = {regfile_raddr_rc_o[IDX_W-1:0],
                       regfile_raddr_rb_o[IDX_W-1:0],
                       regfile_raddr_ra_o[IDX_W-1:0]};
    assign cap_data = {regfile_rdata_rc_i, regfile_rdata_rb_i, regfile_rdata_ra_i};

    assign regfile_wdata_a_o = regfile_we_a_o ? sh_rdata_a : '0;
    assign regfile_wdata_b_o = regfile_we_b_o ? sh_rdata_b : '0;

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic sh_rpar_a;
    logic sh_rpar_b;
    logic par_bad;
    logic par_err_q;

    assign par_bad  = (regfile_we_a_o && ((^sh_rdata_a) != sh_rpar_a)) ||
                      (regfile_we_b_o && ((^sh_rdata_b) != sh_rpar_b));
    assign par_fail = par_err_q | par_bad;

    // Sticky across the restore so a bad word anywhere flags the final done.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else if (state_q == RESTORE) begin
            par_err_q <= par_err_q | par_bad;
        end else begin
            par_err_q <= 1'b0;
        end
    end
`else
    assign par_fail = 1'b0;
`endif

    cv32e40p_rf_shadow #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_shadow (
        .clk     (clk_i),
        .we      (cap_we),
        .waddr   (cap_addr),
        .wdata   (cap_data),
        .raddr_a (regfile_waddr_a_o[IDX_W-1:0]),
        .raddr_b (regfile_waddr_b_o[IDX_W-1:0]),
        .rdata_a (sh_rdata_a),
        .rdata_b (sh_rdata_b)
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        ,
        .rpar_a  (sh_rpar_a),
        .rpar_b  (sh_rpar_b)
`endif
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            beat_q             <= '0;
            busy_o             <= 1'b0;
            backup_done_o      <= 1'b0;
            recover_done_o     <= 1'b0;
            recover_err_o      <= 1'b0;
            ckpt_valid_o       <= 1'b0;
            regfile_backup_o   <= 1'b0;
            regfile_raddr_ra_o <= '0;
            regfile_raddr_rb_o <= '0;
            regfile_raddr_rc_o <= '0;
            recover_o          <= 1'b0;
            regfile_waddr_a_o  <= '0;
            regfile_waddr_b_o  <= '0;
            regfile_we_a_o     <= 1'b0;
            regfile_we_b_o     <= 1'b0;
        end else begin
            backup_done_o  <= 1'b0;
            recover_done_o <= 1'b0;
            recover_err_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    if (recover_req_i) begin
                        busy_o <= 1'b1;
                        if (ckpt_valid_o) begin
                            state_q           <= RESTORE;
                            recover_o         <= 1'b1;
                            regfile_we_a_o    <= 1'b1;
                            regfile_waddr_a_o <= lane_addr(1);
                            regfile_we_b_o    <= (NUM_REGS > 2);
                            regfile_waddr_b_o <= lane_addr(2);
                        end else begin
                            state_q        <= DONE;
                            recover_done_o <= 1'b1;
                            recover_err_o  <= 1'b1;
                        end
                    end else if (backup_req_i) begin
                        state_q            <= BACKUP;
                        busy_o             <= 1'b1;
                        ckpt_valid_o       <= 1'b0;
                        regfile_backup_o   <= 1'b1;
                        regfile_raddr_ra_o <= lane_addr(0);
                        regfile_raddr_rb_o <= lane_addr(1);
                        regfile_raddr_rc_o <= lane_addr(2);
                    end
                end
                BACKUP: begin
                    if (bk_last) begin
                        state_q            <= DONE;
                        ckpt_valid_o       <= 1'b1;
                        backup_done_o      <= 1'b1;
                        regfile_backup_o   <= 1'b0;
                        regfile_raddr_ra_o <= '0;
                        regfile_raddr_rb_o <= '0;
                        regfile_raddr_rc_o <= '0;
                    end else begin
                        beat_q             <= beat_nxt;
                        regfile_raddr_ra_o <= lane_addr(bk_base);
                        regfile_raddr_rb_o <= lane_addr(bk_base + 1);
                        regfile_raddr_rc_o <= lane_addr(bk_base + 2);
                    end
                end
                RESTORE: begin
                    if (rs_last) begin
                        state_q           <= DONE;
                        recover_done_o    <= 1'b1;
                        recover_err_o     <= par_fail;
                        recover_o         <= 1'b0;
                        regfile_we_a_o    <= 1'b0;
                        regfile_we_b_o    <= 1'b0;
                        regfile_waddr_a_o <= '0;
                        regfile_waddr_b_o <= '0;
                    end else begin
                        beat_q            <= beat_nxt;
                        regfile_waddr_a_o <= lane_addr(rs_base);
                        regfile_we_b_o    <= ((rs_base + 1) < NUM_REGS);
                        regfile_waddr_b_o <= lane_addr(rs_base + 1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Self-checking bench: register-file model, checkpoint/restore sequences and a shadow reference model.
// The parity corruption scenario runs only when CV32E40P_RF_RECOVERY_PARITY_EN is defined.
module tb_cv32e40p_rf_recovery_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        backup_req;
    logic        recover_req;
    logic        busy_o, backup_done_o, recover_done_o, recover_err_o, ckpt_valid_o;
    logic        regfile_backup_o, recover_o;
    logic [5:0]  raddr_ra, raddr_rb, raddr_rc;
    logic [31:0] rdata_ra, rdata_rb, rdata_rc;
    logic [5:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b;

    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic [31:0] rf [32];
    logic [31:0] core_val [32];
    logic [31:0] ckpt [64];
    bit          ckpt_valid_m;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cv32e40p_rf_recovery_ctrl #(.NUM_REGS(N)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .backup_req_i       (backup_req),
        .recover_req_i      (recover_req),
        .busy_o             (busy_o),
        .backup_done_o      (backup_done_o),
        .recover_done_o     (recover_done_o),
        .recover_err_o      (recover_err_o),
        .ckpt_valid_o       (ckpt_valid_o),
        .regfile_backup_o   (regfile_backup_o),
        .regfile_raddr_ra_o (raddr_ra),
        .regfile_raddr_rb_o (raddr_rb),
        .regfile_raddr_rc_o (raddr_rc),
        .regfile_rdata_ra_i (rdata_ra),
        .regfile_rdata_rb_i (rdata_rb),
        .regfile_rdata_rc_i (rdata_rc),
        .recover_o          (recover_o),
        .regfile_waddr_a_o  (waddr_a),
        .regfile_waddr_b_o  (waddr_b),
        .regfile_wdata_a_o  (wdata_a),
        .regfile_wdata_b_o  (wdata_b),
        .regfile_we_a_o     (we_a),
        .regfile_we_b_o     (we_b)
    );

    // Core register file: x0 reads as zero, core port plus two recovery write ports.
    always @(posedge clk) begin
        if (core_we) rf[core_waddr] <= core_wdata;
        if (we_a)    rf[waddr_a[4:0]] <= wdata_a;
        if (we_b)    rf[waddr_b[4:0]] <= wdata_b;
    end
    assign rdata_ra = (raddr_ra[4:0] == 5'd0) ? 32'h0 : rf[raddr_ra[4:0]];
    assign rdata_rb = (raddr_rb[4:0] == 5'd0) ? 32'h0 : rf[raddr_rb[4:0]];
    assign rdata_rc = (raddr_rc[4:0] == 5'd0) ? 32'h0 : rf[raddr_rc[4:0]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({busy_o, backup_done_o, recover_done_o, recover_err_o, regfile_backup_o,
                     raddr_ra, raddr_rb, raddr_rc, recover_o, waddr_a, waddr_b,
                     wdata_a, wdata_b, we_a, we_b});
    endfunction

    // mode 0: 0x1000_0000+i, mode 1: 0xDEAD_BEEF, mode 2: random
    task automatic core_fill(input int mode);
        logic [31:0] v;
        for (int i = 1; i < 32; i++) begin
            if (mode == 0)      v = 32'h1000_0000 + i;
            else if (mode == 1) v = 32'hDEAD_BEEF;
            else                v = $urandom;
            core_we    = 1'b1;
            core_waddr = i[4:0];
            core_wdata = v;
            core_val[i] = v;
            @(negedge clk);
        end
        core_we = 1'b0;
    endtask

    task automatic run_backup(input int poke);
        logic [5:0] q[$];
        int lat;
        int beat;
        for (int i = 0; i < N; i++) q.push_back(i[5:0]);
        while ((q.size() % 3) != 0) q.push_back(6'd0);
        backup_req = 1'b1;
        @(negedge clk);
        backup_req = 1'b0;
        beat = 0;
        for (lat = 1; lat <= 60; lat++) begin
            recover_req = (lat == poke);
            if (backup_done_o) break;
            if (regfile_backup_o) begin
                if (q.size() >= 3) begin
                    check("bk_addr", {raddr_ra, raddr_rb, raddr_rc}, {q[0], q[1], q[2]});
                    void'(q.pop_front()); void'(q.pop_front()); void'(q.pop_front());
                end else begin
                    check("bk_extra_beat", beat, (N + 2) / 3);
                end
                if (beat == 0) check("bk_ckpt_cleared", ckpt_valid_o, 1'b0);
                beat++;
            end
            @(negedge clk);
        end
        recover_req = 1'b0;
        check("bk_latency", lat, (N + 2) / 3 + 1);
        check("bk_beats", beat, (N + 2) / 3);
        check("bk_done_state", {backup_done_o, recover_done_o, ckpt_valid_o, busy_o}, 4'b1011);
        for (int i = 1; i < 32; i++) ckpt[i] = core_val[i];
        ckpt_valid_m = 1'b1;
        @(negedge clk);
        check("bk_idle_after", out_vec(), 128'h0);
    endtask

    task automatic run_restore(input int abort_beat, input int poke, input bit both, input bit exp_err);
        logic [5:0] qx[$];
        logic [5:0] qa[$];
        logic [5:0] qb[$];
        bit         qbe[$];
        int lat;
        int beat;
        for (int i = 1; i < N; i++) qx.push_back(i[5:0]);
        while (qx.size() > 0) begin
            qa.push_back(qx.pop_front());
            if (qx.size() > 0) begin qb.push_back(qx.pop_front()); qbe.push_back(1'b1); end
            else begin qb.push_back(6'd0); qbe.push_back(1'b0); end
        end
        recover_req = 1'b1;
        backup_req  = both;
        @(negedge clk);
        recover_req = 1'b0;
        backup_req  = 1'b0;
        beat = 0;
        for (lat = 1; lat <= 60; lat++) begin
            backup_req = (lat == poke);
            if (recover_done_o) break;
            if (recover_o) begin
                if (beat < qa.size()) begin
                    check("rs_port_a", {we_a, waddr_a, wdata_a}, {1'b1, qa[beat], ckpt[qa[beat]]});
                    check("rs_port_b", {we_b, waddr_b, wdata_b},
                          {qbe[beat], qb[beat], qbe[beat] ? ckpt[qb[beat]] : 32'h0});
                end else begin
                    check("rs_extra_beat", beat, N / 2);
                end
                if (beat == abort_beat) begin
                    rst_ni = 1'b0;
                    @(negedge clk);
                    check("abort_outputs", out_vec(), 128'h0);
                    check("abort_ckpt", ckpt_valid_o, 1'b0);
                    rst_ni = 1'b1;
                    ckpt_valid_m = 1'b0;
                    @(negedge clk);
                    check("abort_no_done", {recover_done_o, busy_o}, 2'b00);
                    backup_req = 1'b0;
                    return;
                end
                beat++;
            end else begin
                check("rs_no_write", {we_a, we_b, regfile_backup_o}, 3'b000);
            end
            @(negedge clk);
        end
        backup_req = 1'b0;
        check("rs_latency", lat, ckpt_valid_m ? (N / 2 + 1) : 1);
        check("rs_beats", beat, ckpt_valid_m ? (N / 2) : 0);
        check("rs_done_err", {recover_done_o, recover_err_o, we_a, we_b}, {1'b1, exp_err, 2'b00});
        check("rs_ckpt_valid", ckpt_valid_o, ckpt_valid_m);
        if (ckpt_valid_m) begin
            for (int i = 1; i < 32; i++) check($sformatf("rs_rf_x%0d", i), rf[i], ckpt[i]);
        end
        @(negedge clk);
        check("rs_idle_after", out_vec(), 128'h0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        backup_req   = 1'b0;
        recover_req  = 1'b0;
        core_we      = 1'b0;
        core_waddr   = '0;
        core_wdata   = '0;
        ckpt_valid_m = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 128'h0);
        check("reset_ckpt", ckpt_valid_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Restore without any checkpoint is rejected in one cycle.
        run_restore(-1, -1, 1'b0, 1'b1);

        core_fill(0);
        run_backup(-1);
        core_fill(1);
        run_restore(-1, -1, 1'b0, 1'b0);

        // Both requests together: restore wins, checkpoint is left as it was.
        core_fill(1);
        run_restore(-1, -1, 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            core_fill(2);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_backup($urandom_range(2, 8));
            core_fill(2);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_restore(-1, $urandom_range(2, 10), 1'b0, 1'b0);
        end

        // Reset during restore beat 5, then the lost checkpoint makes restore fail.
        core_fill(1);
        run_restore(5, -1, 1'b0, 1'b0);
        run_restore(-1, -1, 1'b0, 1'b1);

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        begin
            logic [31:0] corrupt;
            core_fill(2);
            run_backup(-1);
            corrupt = ckpt[7] ^ 32'h8;
            force dut.u_shadow.mem[7] = corrupt;
            ckpt[7] = corrupt;
            core_fill(1);
            run_restore(-1, -1, 1'b0, 1'b1);
            release dut.u_shadow.mem[7];
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
